// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, a fill-level output, sticky overflow/underflow flags and a
// selectable first-word-fall-through read mode.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  winc,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic rd_ok;
  logic wr_ok;

  // Status flags decode from the registered count only.
  assign rempty        = (count_q == '0);
  assign wfull         = (count_q == DEPTH_C);
  assign walmost_full  = (count_q >= AF_C);
  assign ralmost_empty = (count_q <= AE_C);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  // A write into a full FIFO is allowed only when a read frees a slot in the
  // same cycle; a read from empty is always rejected (no bypass).
  assign rd_ok = rinc & ~rempty;
  assign wr_ok = winc & (~wfull | rd_ok);

  // Next-state computation for pointers, count and sticky error flags.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;

    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;

    // Clear first so that a same-cycle set overrides it.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (winc && !wr_ok) overflow_d  = 1'b1;
    if (rinc && !rd_ok) underflow_d = 1'b1;
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array write port; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; clearing it would turn it into flops with
    // reset muxes, and stale contents are never visible through the pointers.
    if (rst_n && wr_ok) mem_q[wptr_q] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; valid whenever not empty.
      assign rdata = mem_q[rptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;

      // Registered read: capture the head word on an accepted read, else hold.
      always_ff @(posedge clk) begin
        if (!rst_n)     rdata_q <= '0;
        else if (rd_ok) rdata_q <= mem_q[rptr_q];
      end

      assign rdata = rdata_q;
    end
  endgenerate

endmodule
